reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side front end for the 8-bit register file. Owns the file's single write port: `wr_en`, `MemtoReg`, `wr_addr`, `dat_in`.
- Merges two writers:
  - ALU results, which arrive through a valid/ready handshake into a small FIFO.
  - Load data returning from data memory, which always goes to dedicated register r2.
- Guarantees at most one write per cycle and never asserts `wr_en` and `MemtoReg` together.
- Keeps r2 ordering correct when a load and older ALU writes to r2 overlap.

Parameters:
- DEPTH, 4: ALU write FIFO entries; power of two, at least 2.
- AW, 3: register address width; the file has 2**AW registers.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU write request.
- alu_ready  out  1  FIFO can accept a request.
- alu_addr  in  AW  destination register.
- alu_data  in  8  write data.
- ld_valid  in  1  load data return, one-cycle pulse, always accepted.
- ld_data  in  8  load data.
- wr_en  out  1  register file write enable.
- MemtoReg  out  1  register file dedicated-r2 load write.
- wr_addr  out  AW  register file write address.
- dat_in  out  8  register file write data.
- pend_mask  out  2**AW  bit i is set while a live FIFO entry targets register i.
- fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert use):
  - `wr_en`, `MemtoReg`, `wr_addr`, `dat_in`, `fifo_cnt` and `pend_mask` all go to 0.
  - FIFO is emptied and all entries invalidated.
  - `alu_ready` goes to 1.
  - Reset mid-stream discards every queued write; no write is issued on the first edge after release.
- Accept rules:
  - A request is accepted when `alu_valid` && `alu_ready`.
  - `alu_ready` = (`fifo_cnt` < DEPTH), taken from the registered count.
  - A pop in the full cycle does not raise `alu_ready` in that same cycle.
- Writes to r0 and r1 (hardwired constants):
  - They are accepted, handshake completes, but they are discarded.
  - They are not enqueued, leave no `pend_mask` bit, and cause no write.
- Output stage: all write-port outputs are registered. Each cycle, the next-state choice has this priority:
  1. `ld_valid`: next cycle `MemtoReg`=1, `wr_en`=0, `wr_addr`=2, `dat_in`=`ld_data`.
  2. FIFO head is live: pop it; next cycle `wr_en`=1, `MemtoReg`=0, `wr_addr`/`dat_in` = entry contents.
  3. FIFO head is squashed: pop it with no write; `wr_en`=`MemtoReg`=0 (bubble).
  4. Otherwise idle: `wr_en`=`MemtoReg`=0, and `wr_addr`/`dat_in` hold their previous values.
- Latency:
  - ALU accept to `wr_en` is at least 2 edges: enqueue, then pop into the output register.
  - `ld_valid` to `MemtoReg` is exactly 1 edge.
- r2 squash:
  - On `ld_valid`, every live FIFO entry with addr==2 that is already queued before this edge is marked squashed, because the load is newer.
  - An entry enqueued on the same edge as `ld_valid` is younger and is not squashed.
  - Squashed entries still occupy FIFO slots until popped.
- `pend_mask`:
  - Combinational OR-decode over live, unsquashed entries.
  - Bits 0 and 1 are always 0.
- Ordering: ALU writes retire in strict acceptance order; only loads overtake them.
- Simultaneous enqueue and pop: `fifo_cnt` is unchanged.
- Pointers wrap modulo DEPTH.
- With back-to-back loads, the FIFO is starved; `alu_ready` falls once it fills. There is no deadlock because loads are finite pulses.

Optional Feature:
- Macro: `WB_BYPASS_EN`.
- When defined, an accepted live request bypasses the FIFO and loads the output register directly (latency 1 edge) if, in that cycle:
  - the FIFO is empty (`fifo_cnt`==0), and
  - `ld_valid`=0.
- A bypassed write never touches the FIFO or `pend_mask`.
- When undefined, every accepted write goes through the FIFO (minimum latency 2 edges).
- All other rules are identical in both builds.

Test Plan:
- Reset check: hold `rst_n`=0 for 3 cycles with random inputs -> all outputs 0, `alu_ready`=1. Release, then send `alu_valid` addr=5 data=0x3C -> 2 edges later `wr_en`=1, `wr_addr`=5, `dat_in`=0x3C for exactly 1 cycle (1 edge later with `WB_BYPASS_EN`).
- Fill and drain, with DEPTH=4: send addr 3,4,5,6,7 (data 0x10..0x14) on consecutive cycles -> `alu_ready`=0 once `fifo_cnt`=4 and the 5th request stalls until a pop. Writes appear in order 3..7 with matching data, and `pend_mask` clears per register.
- Load priority: queue addr 4=0xAA, then pulse `ld_valid` `ld_data`=0x55 -> `MemtoReg`=1, `wr_addr`=2, `dat_in`=0x55 first, then `wr_en` addr 4=0xAA. The two are never asserted in the same cycle.
- r2 squash: queue addr 2=0x11, then `ld_valid` 0x99 -> one `MemtoReg` write of 0x99, then a bubble cycle, and 0x11 is never written; `pend_mask`[2] drops on the `ld_valid` edge. Repeat with addr 2=0x22 accepted on the same edge as `ld_valid` -> 0x99, then 0x22 written.
- Constant registers: requests to addr 0=0xFF and addr 1=0xFF -> handshake completes, no `wr_en`, `fifo_cnt` stays 0.
- Reset mid-stream: queue 3 entries, assert `rst_n`=0 for 1 cycle -> outputs 0 immediately (async); after release, no writes occur.

Source files
------------

// File: rtl/reg_writeback.sv
// Write-side front end of the 8-bit register file: ALU writes queue in a FIFO, loads to r2 take priority.
// Define WB_BYPASS_EN to let a live ALU write skip an empty FIFO when no load is returning.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_addr,
  input  logic [7:0]               alu_data,
  input  logic                     ld_valid,
  input  logic [7:0]               ld_data,
  output logic                     wr_en,
  output logic                     MemtoReg,
  output logic [AW-1:0]            wr_addr,
  output logic [7:0]               dat_in,
  output logic [2**AW-1:0]         pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = DEPTH[PW:0];
  localparam logic [AW-1:0] R2      = 2;

  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ent_sq;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [7:0]       ent_data [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      cnt;

  logic accept, drop, bypass, push, pop, head_live;

  assign fifo_cnt  = cnt;
  assign alu_ready = (cnt < DEPTH_C);
  assign accept    = alu_valid && alu_ready;
  // r0/r1 are constants: complete the handshake but never queue or write.
  assign drop      = accept && (alu_addr[AW-1:1] == '0);
`ifdef WB_BYPASS_EN
  assign bypass    = accept && !drop && (cnt == '0) && !ld_valid;
`else
  assign bypass    = 1'b0;
`endif
  assign push      = accept && !drop && !bypass;
  assign pop       = !ld_valid && (cnt != '0);
  assign head_live = ent_vld[rd_ptr] && !ent_sq[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
      ent_sq  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
    end else begin
      // A returning load is newer than every queued r2 write; a same-edge push overrides below.
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_valid && ent_vld[i] && (ent_addr[i] == R2)) begin
          ent_sq[i] <= 1'b1;
        end
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        ent_sq[wr_ptr]  <= 1'b0;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= alu_addr;
      ent_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      MemtoReg <= 1'b0;
      wr_addr  <= '0;
      dat_in   <= '0;
    end else begin
      wr_en    <= 1'b0;
      MemtoReg <= 1'b0;
      if (ld_valid) begin
        MemtoReg <= 1'b1;
        wr_addr  <= R2;
        dat_in   <= ld_data;
      end else if (pop) begin
        if (head_live) begin
          wr_en   <= 1'b1;
          wr_addr <= ent_addr[rd_ptr];
          dat_in  <= ent_data[rd_ptr];
        end
      end else if (bypass) begin
        wr_en   <= 1'b1;
        wr_addr <= alu_addr;
        dat_in  <= alu_data;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && !ent_sq[i]) begin
        pend_mask[ent_addr[i]] = 1'b1;
      end
    end
    pend_mask[1:0] = 2'b00;
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback (DEPTH=4, AW=3): every register-file write is popped and compared in order.
module tb_reg_writeback;

  logic       clk;
  logic       rst_n;
  logic       alu_valid;
  logic       alu_ready;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       wr_en;
  logic       MemtoReg;
  logic [2:0] wr_addr;
  logic [7:0] dat_in;
  logic [7:0] pend_mask;
  logic [2:0] fifo_cnt;

  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  reg_writeback #(.DEPTH(4), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .wr_en(wr_en), .MemtoReg(MemtoReg), .wr_addr(wr_addr), .dat_in(dat_in),
    .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ew(input logic ld, input logic [2:0] a, input logic [7:0] d);
    return {ld, a, d};
  endfunction

  // Scoreboard: every write seen on the port must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (wr_en || MemtoReg)) begin
      checks++;
      if (wr_en && MemtoReg) begin
        failures++;
        $display("FAIL both_strobes: wr_en=%0b MemtoReg=%0b, required not both", wr_en, MemtoReg);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: ld=%0b addr=%0d data=%h, required no write", MemtoReg, wr_addr, dat_in);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({MemtoReg, wr_addr, dat_in} !== e) begin
          failures++;
          $display("FAIL write_order: got ld=%0b addr=%0d data=%h, required ld=%0b addr=%0d data=%h",
                   MemtoReg, wr_addr, dat_in, e[11], e[10:8], e[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    repeat (6) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if ({fifo_cnt, pend_mask} !== 11'd0) begin
      failures++;
      $display("FAIL %s_idle: fifo_cnt=%0d pend_mask=%b, required 0 and 0", name, fifo_cnt, pend_mask);
    end
    tick();
  endtask

  task automatic test_reset();
    int lat;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      alu_valid = 1'($urandom);
      alu_addr  = 3'($urandom);
      alu_data  = 8'($urandom);
      ld_valid  = 1'($urandom);
      ld_data   = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({wr_en, MemtoReg, wr_addr, dat_in, pend_mask, fifo_cnt, alu_ready} !== 25'h1) begin
        failures++;
        $display("FAIL reset_state: wr_en=%0b MemtoReg=%0b addr=%0d dat=%h pend=%b cnt=%0d ready=%0b, required zeros and ready=1",
                 wr_en, MemtoReg, wr_addr, dat_in, pend_mask, fifo_cnt, alu_ready);
      end
    end
    tick();
    rst_n = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0; alu_addr = '0; alu_data = '0; ld_data = '0;
    tick();
    checks++;
    if ((wr_en | MemtoReg) !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_edge: wr_en=%0b MemtoReg=%0b, required 0", wr_en, MemtoReg);
    end
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 8'h3C;
    exp_q.push_back(ew(1'b0, 3'd5, 8'h3C));
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      alu_valid = 1'b0;
      lat++;
      @(negedge clk);
    end while (!wr_en && lat < 10);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL alu_latency: %0d edges, required 2", lat);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0) begin
      failures++;
      $display("FAIL alu_single_cycle: wr_en=%0b, required 0", wr_en);
    end
    wait_idle("reset");
  endtask

  task automatic test_fill_drain();
    int  sent;
    bit  acc;
    bit  saw_full;
    bit  saw_stall;
    sent = 0; saw_full = 0; saw_stall = 0;
    for (int j = 0; j < 5; j++) exp_q.push_back(ew(1'b1, 3'd2, 8'hA0 + 8'(j)));
    for (int j = 0; j < 5; j++) exp_q.push_back(ew(1'b0, 3'(3 + j), 8'h10 + 8'(j)));
    for (int c = 0; c < 40 && sent < 5; c++) begin
      ld_valid  = (c < 5);
      ld_data   = 8'hA0 + 8'(c);
      alu_valid = 1'b1;
      alu_addr  = 3'(3 + sent);
      alu_data  = 8'h10 + 8'(sent);
      @(negedge clk);
      if (fifo_cnt == 3'd4 && !saw_full) begin
        saw_full = 1;
        checks++;
        if (alu_ready !== 1'b0) begin
          failures++;
          $display("FAIL full_ready: alu_ready=%0b, required 0", alu_ready);
        end
        checks++;
        if (pend_mask !== 8'h78) begin
          failures++;
          $display("FAIL full_pend_mask: %b, required 01111000", pend_mask);
        end
      end
      if (!alu_ready) saw_stall = 1;
      acc = alu_ready;
      tick();
      if (acc) sent++;
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    checks++;
    if (!(saw_full && saw_stall && sent == 5)) begin
      failures++;
      $display("FAIL fill_stall: full=%0b stall=%0b sent=%0d, required 1 1 5", saw_full, saw_stall, sent);
    end
    wait_idle("fill");
  endtask

  task automatic test_load_priority();
    exp_q.push_back(ew(1'b1, 3'd2, 8'h55));
    exp_q.push_back(ew(1'b0, 3'd4, 8'hAA));
    alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 8'hAA;
    tick();
    alu_valid = 1'b0;
    checks++;
    if ({fifo_cnt, pend_mask} !== {3'd1, 8'h10}) begin
      failures++;
      $display("FAIL ldprio_queued: cnt=%0d pend=%b, required 1 00010000", fifo_cnt, pend_mask);
    end
    ld_valid = 1'b1; ld_data = 8'h55;
    tick();
    ld_valid = 1'b0;
    wait_idle("ldprio");
  endtask

  task automatic test_squash();
    exp_q.push_back(ew(1'b1, 3'd2, 8'h99));
    alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 8'h11;
    tick();
    alu_valid = 1'b0;
    checks++;
    if (pend_mask !== 8'h04) begin
      failures++;
      $display("FAIL squash_pend_before: %b, required 00000100", pend_mask);
    end
    ld_valid = 1'b1; ld_data = 8'h99;
    tick();
    ld_valid = 1'b0;
    checks++;
    if ({fifo_cnt, pend_mask} !== {3'd1, 8'h00}) begin
      failures++;
      $display("FAIL squash_pend_after: cnt=%0d pend=%b, required 1 00000000", fifo_cnt, pend_mask);
    end
    tick();
    checks++;
    if ({wr_en, MemtoReg, fifo_cnt} !== 5'd0) begin
      failures++;
      $display("FAIL squash_bubble: wr_en=%0b MemtoReg=%0b cnt=%0d, required 0 0 0", wr_en, MemtoReg, fifo_cnt);
    end
    wait_idle("squash");

    exp_q.push_back(ew(1'b1, 3'd2, 8'h99));
    exp_q.push_back(ew(1'b0, 3'd2, 8'h22));
    alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 8'h11;
    tick();
    alu_data = 8'h22; ld_valid = 1'b1; ld_data = 8'h99;
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    checks++;
    if ({fifo_cnt, pend_mask} !== {3'd2, 8'h04}) begin
      failures++;
      $display("FAIL squash_same_edge: cnt=%0d pend=%b, required 2 00000100", fifo_cnt, pend_mask);
    end
    wait_idle("squash2");
  endtask

  task automatic test_const_regs();
    for (int r = 0; r < 2; r++) begin
      alu_valid = 1'b1; alu_addr = 3'(r); alu_data = 8'hFF;
      @(negedge clk);
      checks++;
      if (alu_ready !== 1'b1) begin
        failures++;
        $display("FAIL const_ready_r%0d: alu_ready=%0b, required 1", r, alu_ready);
      end
      tick();
      alu_valid = 1'b0;
      checks++;
      if ({fifo_cnt, pend_mask} !== 11'd0) begin
        failures++;
        $display("FAIL const_dropped_r%0d: cnt=%0d pend=%b, required 0 0", r, fifo_cnt, pend_mask);
      end
    end
    wait_idle("const");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      alu_valid = 1'b1;
      alu_addr  = 3'($urandom_range(7, 3));
      alu_data  = 8'($urandom);
      exp_q.push_back(ew(1'b0, alu_addr, alu_data));
      tick();
    end
    alu_valid = 1'b0;
    wait_idle("b2b");
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 3; c++) begin
      ld_valid  = 1'b1; ld_data = 8'hC0 + 8'(c);
      alu_valid = 1'b1; alu_addr = 3'(3 + c); alu_data = 8'h30 + 8'(c);
      exp_q.push_back(ew(1'b1, 3'd2, 8'hC0 + 8'(c)));
      tick();
    end
    ld_valid = 1'b0; alu_valid = 1'b0;
    checks++;
    if (fifo_cnt !== 3'd3) begin
      failures++;
      $display("FAIL midrst_queued: cnt=%0d, required 3", fifo_cnt);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, MemtoReg, wr_addr, dat_in, pend_mask, fifo_cnt, alu_ready} !== 25'h1) begin
      failures++;
      $display("FAIL midrst_async: wr_en=%0b MemtoReg=%0b addr=%0d dat=%h pend=%b cnt=%0d ready=%0b, required zeros and ready=1",
               wr_en, MemtoReg, wr_addr, dat_in, pend_mask, fifo_cnt, alu_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("midrst");
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_addr = '0; alu_data = '0; ld_valid = 1'b0; ld_data = '0;
    test_reset();
    test_fill_drain();
    test_load_priority();
    test_squash();
    test_const_regs();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
